// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and response record shared by the
// ALU command driver and its optional response FIFO.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_SLT     = 3'd2;
    localparam logic [2:0] OP_XOR     = 3'd3;
    localparam logic [2:0] OP_SHL     = 3'd4;
    localparam logic [2:0] OP_SHR     = 3'd5;
    localparam logic [2:0] OP_SRA     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             zero;
        logic             ovf;
        logic             cout;
        logic             err;
    } rsp_t;

    function automatic rsp_t err_rsp();
        rsp_t r;
        r     = '0;
        r.err = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: 2-entry response FIFO; simultaneous push and pop
// leaves occupancy unchanged. Caller never pushes when full.
module alu_rsp_fifo
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_t       push_data,
    input  logic       pop,
    output rsp_t       head,
    output logic [1:0] occ
);

    rsp_t mem [2];
    logic wr_ptr;
    logic rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: registered valid/ready front-end for the 32-bit ALU.
// Define ALU_CMD_DRIVER_SKID_EN for a 2-entry response FIFO.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    state_t state;
    state_t state_nx;
    rsp_t   cap;
    rsp_t   rsp_q;
    logic   take_ok;
    logic   legal;
    logic   accept;
    logic   deliver;

    assign legal   = req_op != OP_ILLEGAL;
    assign accept  = req_valid && take_ok;
    assign deliver = rsp_valid && rsp_ready;

    assign req_ready = take_ok;

    assign cap.data = alu_out;
    assign cap.zero = alu_zero;
    assign cap.ovf  = alu_ovf;
    assign cap.cout = alu_cout;
    assign cap.err  = 1'b0;

    assign rsp_data = rsp_q.data;
    assign rsp_zero = rsp_q.zero;
    assign rsp_ovf  = rsp_q.ovf;
    assign rsp_cout = rsp_q.cout;
    assign rsp_err  = rsp_q.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The ALU bus only moves on a legal acceptance; illegal ops leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s <= 3'd0;
            alu_a <= '0;
            alu_b <= '0;
        end else if (accept && legal) begin
            alu_s <= req_op;
            alu_a <= req_a;
            alu_b <= req_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (deliver) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef ALU_CMD_DRIVER_SKID_EN
    rsp_t       push_data;
    logic       push;
    logic       in_flight;
    logic [1:0] occ;

    assign in_flight = state == ST_EXEC;
    assign push      = in_flight || (accept && !legal);
    assign push_data = in_flight ? cap : err_rsp();
    assign take_ok   = (state == ST_IDLE) && ((occ + {1'b0, in_flight}) < 2'd2);
    assign rsp_valid = occ != 2'd0;

    alu_rsp_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (deliver),
        .head      (rsp_q),
        .occ       (occ)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept && legal) state_nx = ST_EXEC;
            default: state_nx = ST_IDLE;
        endcase
    end
`else
    assign take_ok   = state == ST_IDLE;
    assign rsp_valid = state == ST_RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (state == ST_EXEC) begin
            rsp_q <= cap;
        end else if (accept && !legal) begin
            rsp_q <= err_rsp();
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = legal ? ST_EXEC : ST_RESP;
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized bench with an ALU model on the bus and a
// queue-based reference of expected responses (CNT_W=4 to reach wrap).
module tb_alu_cmd_driver;

    localparam int W    = 32;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        o;
        logic        c;
        logic        e;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [2:0]    alu_s;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_out;
    logic          alu_zero;
    logic          alu_ovf;
    logic          alu_cout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_zero;
    logic          rsp_ovf;
    logic          rsp_cout;
    logic          rsp_err;
    logic [CW-1:0] op_count;

    int n_cmp;
    int n_bad;
    int exp_cnt;

    alu_cmd_driver #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic definition of each opcode; also serves as the ALU on the bus.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [32:0] s;
        r = '0;
        case (op)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                r.d = s[31:0];
                r.c = s[32];
                r.o = (a[31] == b[31]) && (r.d[31] != a[31]);
            end
            3'd1: begin
                s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.d = s[31:0];
                r.c = s[32];
                r.o = (a[31] != b[31]) && (r.d[31] != a[31]);
            end
            3'd2: r.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r.d = a ^ b;
            3'd4: r.d = a << b[4:0];
            3'd5: r.d = a >> b[4:0];
            3'd6: r.d = $unsigned($signed(a) >>> b[4:0]);
            default: r.e = 1'b1;
        endcase
        if (!r.e) r.z = r.d == 32'd0;
        return r;
    endfunction

    exp_t alu_env;
    always_comb alu_env = ref_model(alu_s, alu_a, alu_b);
    assign alu_out  = alu_env.d;
    assign alu_zero = alu_env.z;
    assign alu_ovf  = alu_env.o;
    assign alu_cout = alu_env.c;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pick(input bit legal_only, output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
        op = legal_only ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
        a  = $urandom;
        case ($urandom_range(0, 3))
            0: b = a;
            1: b = $urandom_range(0, 40);
            default: b = $urandom;
        endcase
    endtask

    // Presents one request and returns #1 after the edge that accepted it.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done      = 1'b0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_accept: got no acceptance want accept within 20 cycles");
        end
    endtask

    task automatic deliver_one();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt   = (exp_cnt + 1) % CMOD;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_cnt = 0;
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_hs: got %b want 10", {req_ready, rsp_valid});
        end
        n_cmp++;
        if ({rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err});
        end
        n_cmp++;
        if ({alu_s, alu_a, alu_b, op_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got %h %h %h %h want 0", alu_s, alu_a, alu_b, op_count);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        send(3'd0, 32'd5, 32'd7);
        n_cmp++;
        if ({alu_s, alu_a, alu_b, rsp_valid} !== {3'd0, 32'd5, 32'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL add_bus: got s=%0d a=%0d b=%0d v=%b want 0 5 7 0", alu_s, alu_a, alu_b, rsp_valid);
        end
`ifndef ALU_CMD_DRIVER_SKID_EN
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL add_busy: got req_ready=%b want 0", req_ready);
        end
`endif
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err} !== {1'b1, 32'd12, 4'b0}) begin
            n_bad++;
            $display("FAIL add_rsp: got v=%b d=%h f=%b want 1 0000000c 0000", rsp_valid, rsp_data,
                     {rsp_zero, rsp_ovf, rsp_cout, rsp_err});
        end
        deliver_one();
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, CW'(exp_cnt)} || exp_cnt != 1) begin
            n_bad++;
            $display("FAIL add_count: got v=%b cnt=%0d want 0 1", rsp_valid, op_count);
        end
    endtask

    task automatic test_sub();
        send(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_ovf, rsp_err} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_ovf: got v=%b d=%h ovf=%b err=%b want 1 80000000 1 0", rsp_valid, rsp_data,
                     rsp_ovf, rsp_err);
        end
        deliver_one();
        send(3'd1, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_zero: got v=%b d=%h z=%b err=%b want 1 0 1 0", rsp_valid, rsp_data,
                     rsp_zero, rsp_err);
        end
        deliver_one();
    endtask

    task automatic test_illegal();
        send(3'd7, $urandom, $urandom);
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err} !== {1'b1, 32'd0, 4'b0001}) begin
            n_bad++;
            $display("FAIL illegal_rsp: got v=%b d=%h f=%b want 1 0 0001", rsp_valid, rsp_data,
                     {rsp_zero, rsp_ovf, rsp_cout, rsp_err});
        end
        n_cmp++;
        if ({alu_s, alu_a, alu_b} !== {3'd1, 32'd3, 32'd3}) begin
            n_bad++;
            $display("FAIL illegal_bus: got %0d %h %h want 1 3 3", alu_s, alu_a, alu_b);
        end
        deliver_one();
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, CW'(exp_cnt)}) begin
            n_bad++;
            $display("FAIL illegal_count: got v=%b cnt=%0d want 0 %0d", rsp_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        stable = 1'b1;
        send(3'd3, 32'hF0F0_F0F0, 32'hFFFF_0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'h0F0F_F0F0, 1'b0}) stable = 1'b0;
`ifndef ALU_CMD_DRIVER_SKID_EN
            if (req_ready !== 1'b0) stable = 1'b0;
`endif
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL hold_stable: got v=%b d=%h rdy=%b want held 1 0f0ff0f0", rsp_valid, rsp_data, req_ready);
        end
        deliver_one();
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, CW'(exp_cnt)}) begin
            n_bad++;
            $display("FAIL hold_release: got v=%b cnt=%0d want 0 %0d", rsp_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit   quiet;
        exp_t want;
        logic [31:0] a;
        logic [31:0] b;
        quiet = 1'b1;
        send(3'd0, 32'h1234, 32'h4321);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_s, alu_a, alu_b, op_count} !== {2'b10, 33'd0, 3'd0, 64'd0, CW'(0)}) begin
            n_bad++;
            $display("FAIL rstmid_outs: got rdy=%b v=%b d=%h a=%h cnt=%0d want reset values", req_ready,
                     rsp_valid, rsp_data, alu_a, op_count);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (!quiet || op_count !== CW'(0)) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got stray response (cnt=%0d) want none", op_count);
        end
        a    = $urandom;
        b    = $urandom;
        want = ref_model(3'd3, a, b);
        send(3'd3, a, b);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err} !== {1'b1, want}) begin
            n_bad++;
            $display("FAIL rstmid_fresh: got %b_%h want 1_%h", rsp_valid, rsp_data, want.d);
        end
        deliver_one();
    endtask

    task automatic test_wrap();
        while (exp_cnt != CMOD - 1) begin
            send(3'd7, $urandom, $urandom);
            deliver_one();
        end
        n_cmp++;
        if (op_count !== CW'(CMOD - 1)) begin
            n_bad++;
            $display("FAIL wrap_top: got %0d want %0d", op_count, CMOD - 1);
        end
        send(3'd7, $urandom, $urandom);
        deliver_one();
        n_cmp++;
        if (op_count !== CW'(0) || exp_cnt != 0) begin
            n_bad++;
            $display("FAIL wrap_zero: got %0d want 0", op_count);
        end
    endtask

    // Free-running stream: reference queue filled on acceptance, drained in order.
    task automatic run_stream(input int n, input bit rand_ready, input bit legal_only, output int cycles);
        exp_t        q[$];
        exp_t        got;
        exp_t        want;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sent;
        int          recv;
        bit          acc;
        bit          del;
        sent   = 0;
        recv   = 0;
        cycles = 0;
        pick(legal_only, op, a, b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (recv < n && cycles < 12 * n + 20) begin
            acc = req_valid && req_ready;
            del = rsp_valid && rsp_ready;
            got = {rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err};
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                q.push_back(ref_model(req_op, req_a, req_b));
                sent++;
                if (sent < n) begin
                    pick(legal_only, op, a, b);
                    req_op = op;
                    req_a  = a;
                    req_b  = b;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (del) begin
                recv++;
                exp_cnt = (exp_cnt + 1) % CMOD;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got response %h want none", got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL stream_rsp #%0d: got %h want %h", recv, got, want);
                    end
                end
                n_cmp++;
                if (op_count !== CW'(exp_cnt)) begin
                    n_bad++;
                    $display("FAIL stream_count: got %0d want %0d", op_count, exp_cnt);
                end
            end
            if (rand_ready) rsp_ready = $urandom_range(0, 3) != 0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (recv != n) begin
            n_bad++;
            $display("FAIL stream_done: got %0d responses want %0d", recv, n);
        end
    endtask

    task automatic test_random();
        int cyc;
        run_stream(40, 1'b1, 1'b0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int want;
        run_stream(20, 1'b0, 1'b1, cyc);
`ifdef ALU_CMD_DRIVER_SKID_EN
        want = 2 * 20 + 1;
`else
        want = 3 * 20;
`endif
        n_cmp++;
        if (cyc != want) begin
            n_bad++;
            $display("FAIL b2b_cycles: got %0d want %0d", cyc, want);
        end
    endtask

`ifdef ALU_CMD_DRIVER_SKID_EN
    task automatic test_skid_full();
        exp_t        q[$];
        exp_t        want;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          acc_n;
        bit          acc;
        acc_n     = 0;
        rsp_ready = 1'b0;
        pick(1'b1, op, a, b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                q.push_back(ref_model(req_op, req_a, req_b));
                acc_n++;
                pick(1'b1, op, a, b);
                req_op = op;
                req_a  = a;
                req_b  = b;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (acc_n != 2 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL skid_full: got %0d accepts rdy=%b want 2 0", acc_n, req_ready);
        end
        for (int i = 0; i < 2 && q.size() > 0; i++) begin
            want = q.pop_front();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err} !== {1'b1, want}) begin
                n_bad++;
                $display("FAIL skid_drain #%0d: got %b_%h want 1_%h", i, rsp_valid, rsp_data, want.d);
            end
            deliver_one();
        end
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, CW'(exp_cnt)}) begin
            n_bad++;
            $display("FAIL skid_empty: got v=%b cnt=%0d want 0 %0d", rsp_valid, op_count, exp_cnt);
        end
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        test_reset();
        test_add();
        test_sub();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        test_back_to_back();
`ifdef ALU_CMD_DRIVER_SKID_EN
        test_skid_full();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential command front-end for the 32-bit combinational ALU. Accepts operation requests over a valid/ready handshake, registers the opcode and operands onto the ALU input bus, and captures the ALU result and flags one cycle later. It returns each result over a second valid/ready handshake with backpressure. It sits between the instruction/test sequencer and the ALU, driving the ALU's S/A/B inputs and sampling its out/Zero/Overflow/Cout outputs.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  3  ALU opcode.
  - 0 add, 1 sub, 2 slt, 3 xor, 4/5/6 shift.
  - 7 illegal.
- req_a, req_b  input  WIDTH  operands.
- alu_s  output  3  opcode to ALU.
- alu_a, alu_b  output  WIDTH  operands to ALU.
- alu_out  input  WIDTH  ALU result.
- alu_zero, alu_ovf, alu_cout  input  1  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  captured result.
- rsp_zero, rsp_ovf, rsp_cout  output  1  captured flags.
- rsp_err  output  1  response is for an illegal opcode.
- op_count  output  CNT_W  number of responses delivered; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_op/req_a/req_b into the alu_s/alu_a/alu_b registers.
  - Go to EXEC, unless the opcode is illegal.
- Illegal opcode (7):
  - alu_* registers keep their previous values.
  - Load the response with rsp_data=0, flags=0, rsp_err=1.
  - Go directly to RESP.
- EXEC: ALU inputs are stable for the whole cycle. At the cycle end, capture alu_out and the three flags into the response registers with rsp_err=0, then go to RESP.
- RESP:
  - rsp_valid=1. Response outputs hold steady until the handshake.
  - On rsp_valid&&rsp_ready: increment op_count and return to IDLE.
  - Error responses count too.
- alu_s/alu_a/alu_b hold their last issued values outside EXEC. They change only on acceptance of a legal request.
- Reset mid-operation: any in-flight request is discarded, with no response. All registers go to reset values immediately.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0.
  - rsp_data=0; rsp_zero, rsp_ovf, rsp_cout, rsp_err = 0.
  - alu_s=0, alu_a=0, alu_b=0.
  - op_count=0. FSM in IDLE.
- Legal request accepted at edge t: ALU driven from t; capture at t+1; rsp_valid high from t+1 (after edge t+1).
- Illegal request accepted at t: rsp_valid high after edge t.
- Base build: one outstanding operation.
  - req_ready=0 in EXEC and RESP.
  - Minimum 3 cycles per legal operation with rsp_ready held high.
- rsp_ready held low: the block stays in RESP indefinitely with stable outputs.
- op_count at all-ones plus one delivery wraps to 0.

## Configuration
- ALU_CMD_DRIVER_SKID_EN defined: adds a 2-entry response FIFO between capture and the rsp_* outputs.
  - FSM leaves EXEC to IDLE; RESP is not used.
  - req_ready = (FIFO occupancy + in-flight) < 2.
  - Sustained throughput is 1 op per 2 cycles.
  - A simultaneous FIFO push and pop keeps occupancy unchanged.
  - Responses are delivered strictly in acceptance order.
- Undefined: single-response register, behaviour exactly as above.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_SLT=2, OP_XOR=3, OP_SHL=4, OP_SHR=5, OP_SRA=6, OP_ILLEGAL=7.
  - The FSM state encoding.
  - The response record layout (data, zero, ovf, cout, err).
- Sub-module alu_rsp_fifo: 2-entry FIFO, instantiated only under ALU_CMD_DRIVER_SKID_EN.

## Test plan
- Reset, then add with a=5, b=7:
  - alu_s=0, alu_a=5, alu_b=7 during EXEC.
  - rsp_data=12, flags 0, response 2 cycles after acceptance.
  - op_count=1.
- Sub with a=0x7FFFFFFF, b=0xFFFFFFFF (overflow case):
  - rsp_ovf=1, rsp_data=0x80000000.
  - Sub 3-3: rsp_zero=1, rsp_data=0.
- Opcode 7:
  - rsp_err=1, rsp_data=0, response 1 cycle after acceptance.
  - alu_* unchanged; op_count increments.
- Hold rsp_ready=0 for 10 cycles after an xor of 0xF0F0F0F0 and 0xFFFF0000:
  - rsp_data=0x0F0FF0F0 stable throughout; req_ready=0.
  - Accept on release.
- Assert rst_n low during EXEC:
  - All outputs at reset values immediately; no response emitted.
  - A fresh request afterwards completes normally.
- Skid build: back-to-back stream with rsp_ready=1 gives 1 response per 2 cycles in order.
- Skid build, rsp_ready=0: req_ready drops after 2 accepted requests.
- op_count preloaded near wrap via 2^CNT_W deliveries (CNT_W=4 build): value 15 -> 0.
